// File: rtl/tm_key_events.sv
// Debounces the TM1638 8-bit key vector and queues press/release events in a show-ahead FIFO.
// Define REPEAT_EN to add auto-repeat events for the most recently pressed key.
module tm_key_events #(
  parameter int TICK_DIV     = 25000,
  parameter int DEB_TICKS    = 20,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys_raw,
  output logic [7:0] keys_stable,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [4:0] ev_data,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [7:0]    keys_q, keys_d;
  logic [7:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  logic [7:0]    press_set, rel_set;
  logic [7:0]    press_pend_q, press_pend_d, press_clr;
  logic [7:0]    rel_pend_q, rel_pend_d, rel_clr;
  logic [2:0]    press_idx, rel_idx;
  logic          sel_vld, rep_clr;
  logic [4:0]    sel_data;
  logic          push_vld_q, push_vld_d;
  logic [4:0]    push_data_q, push_data_d;
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [4:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, pop, push, drop;

`ifdef REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic          rep_act_q, rep_act_d;
  logic [2:0]    rep_idx_q, rep_idx_d, new_idx;
  logic [RW-1:0] rep_tmr_q, rep_tmr_d;
  logic          rep_pend_q, rep_pend_d;
`else
  logic          rep_pend_q;
  logic [2:0]    rep_idx_q;
  logic          unused_rep;
  assign rep_pend_q = 1'b0;
  assign rep_idx_q  = 3'd0;
  assign unused_rep = rep_clr & (REPEAT_DELAY > 0) & (REPEAT_RATE > 0);
`endif

  always_comb begin
    tick      = (presc_q == PW'(TICK_DIV - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    keys_d    = keys_raw;
    stable_d  = stable_q;
    press_set = '0;
    rel_set   = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (keys_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(DEB_TICKS - 1)) begin
          cnt_d[i]     = '0;
          stable_d[i]  = keys_q[i];
          press_set[i] = keys_q[i];
          rel_set[i]   = ~keys_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // Fixed priority: presses, then releases, lowest index first, then repeat.
    press_idx = '0;
    rel_idx   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (press_pend_q[i]) press_idx = 3'(i);
      if (rel_pend_q[i])   rel_idx   = 3'(i);
    end
    sel_vld   = 1'b0;
    sel_data  = '0;
    press_clr = '0;
    rel_clr   = '0;
    rep_clr   = 1'b0;
    if (|press_pend_q) begin
      sel_vld              = 1'b1;
      sel_data             = {2'b00, press_idx};
      press_clr[press_idx] = 1'b1;
    end else if (|rel_pend_q) begin
      sel_vld          = 1'b1;
      sel_data         = {2'b01, rel_idx};
      rel_clr[rel_idx] = 1'b1;
    end else if (rep_pend_q) begin
      sel_vld  = 1'b1;
      sel_data = {2'b10, rep_idx_q};
      rep_clr  = 1'b1;
    end
    press_pend_d = (press_pend_q & ~press_clr) | press_set;
    rel_pend_d   = (rel_pend_q & ~rel_clr) | rel_set;
    push_vld_d   = sel_vld;
    push_data_d  = sel_data;

`ifdef REPEAT_EN
    new_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (press_set[i]) new_idx = 3'(i);
    end
    rep_act_d  = rep_act_q;
    rep_idx_d  = rep_idx_q;
    rep_tmr_d  = rep_tmr_q;
    rep_pend_d = rep_pend_q & ~rep_clr;
    if (|press_set) begin
      rep_act_d = 1'b1;
      rep_idx_d = new_idx;
      rep_tmr_d = RW'(REPEAT_DELAY);
    end else if (rep_act_q && rel_set[rep_idx_q]) begin
      rep_act_d  = 1'b0;
      rep_pend_d = 1'b0;
    end else if (rep_act_q && tick) begin
      if (rep_tmr_q == RW'(1)) begin
        rep_pend_d = 1'b1;
        rep_tmr_d  = RW'(REPEAT_RATE);
      end else begin
        rep_tmr_d = rep_tmr_q - 1'b1;
      end
    end
`endif

    // A push into a full FIFO still succeeds if the head leaves this cycle.
    full     = (count_q == OW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    pop      = !empty && ev_ready;
    push     = push_vld_q && (!full || pop);
    drop     = push_vld_q && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = clr_overflow ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      keys_q       <= '0;
      stable_q     <= '0;
      cnt_q        <= '{default: '0};
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      push_vld_q   <= 1'b0;
      push_data_q  <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
`ifdef REPEAT_EN
      rep_act_q    <= 1'b0;
      rep_idx_q    <= '0;
      rep_tmr_q    <= '0;
      rep_pend_q   <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      keys_q       <= keys_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      push_vld_q   <= push_vld_d;
      push_data_q  <= push_data_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
`ifdef REPEAT_EN
      rep_act_q    <= rep_act_d;
      rep_idx_q    <= rep_idx_d;
      rep_tmr_q    <= rep_tmr_d;
      rep_pend_q   <= rep_pend_d;
`endif
    end
  end

  assign keys_stable = stable_q;
  assign ev_valid    = !empty;
  assign ev_data     = empty ? 5'd0 : mem_q[rd_ptr_q];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_tm_key_events.sv
// Bench for tm_key_events: directed scenarios plus random key activity, checked against
// an event-list reference model of the debounce/repeat rules.
module tb_tm_key_events;
  localparam int TD = 16, DEB = 4, DEPTH = 8, RD = 10, RR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys_raw = 8'h00;
  logic       ev_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] keys_stable;
  logic       ev_valid, overflow;
  logic [4:0] ev_data;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tm_key_events #(.TICK_DIV(TD), .DEB_TICKS(DEB), .FIFO_DEPTH(DEPTH),
                  .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .keys_stable(keys_stable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .overflow(overflow), .clr_overflow(clr_overflow));

  // reference model: sampled keys, debounced keys, per-key tick run lengths, expected events
  logic [7:0] m_kq = 8'h00, m_st = 8'h00;
  int         m_cnt [8];
  int         m_cyc = 0, m_rep_key = -1, m_rep_age = 0;
  logic [4:0] exp_q [$];

  logic [7:0] s_stable;
  logic       s_valid, s_ovf, popped;
  logic [4:0] s_data, pop_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    logic [7:0] ps, rs;
    bit tick;
    if (rst) begin
      m_kq = 8'h00; m_st = 8'h00; m_cyc = 0; m_rep_key = -1; m_rep_age = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      exp_q.delete();
      return;
    end
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    ps = 8'h00; rs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m_kq[i] != m_st[i]) begin
        if (tick) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_st[i] = m_kq[i]; m_cnt[i] = 0;
            if (m_kq[i]) ps[i] = 1'b1; else rs[i] = 1'b1;
          end
        end
      end else m_cnt[i] = 0;
    end
    for (int i = 0; i < 8; i++) if (ps[i]) exp_q.push_back({2'b00, 3'(i)});
    for (int i = 0; i < 8; i++) if (rs[i]) exp_q.push_back({2'b01, 3'(i)});
`ifdef REPEAT_EN
    if (ps != 8'h00) begin
      for (int i = 7; i >= 0; i--) if (ps[i]) m_rep_key = i;
      m_rep_age = 0;
    end else if (m_rep_key >= 0 && rs[m_rep_key]) begin
      m_rep_key = -1;
    end else if (m_rep_key >= 0 && tick) begin
      m_rep_age++;
      if (m_rep_age == RD || (m_rep_age > RD && (m_rep_age - RD) % RR == 0))
        exp_q.push_back({2'b10, 3'(m_rep_key)});
    end
`endif
    m_kq = keys_raw;
  endtask

  task automatic step();
    @(negedge clk);
    s_stable = keys_stable; s_valid = ev_valid; s_data = ev_data; s_ovf = overflow;
    popped = 1'b0;
    if (ev_valid && ev_ready) begin
      popped = 1'b1; pop_data = ev_data;
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL ev_unexpected observed=%0h expected=none", ev_data);
        end
      end else chk("ev_stream", ev_data, exp_q.pop_front());
    end
    chk("keys_stable", keys_stable, m_st);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_stable(input logic [7:0] v, input int maxc, input string tag);
    int n = 0;
    while (s_stable !== v && n < maxc) begin step(); n++; end
    chk(tag, s_stable, v);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (s_valid !== 1'b1 && n < maxc) begin step(); n++; end
    chk(tag, s_valid, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, npop, nrep, b, hold;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_stable", s_stable, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_data", s_data, 0);
    chk("rst_ovf", s_ovf, 0);
    rst = 1'b0; ev_ready = 1'b1;

    // single key press/release, including push latency
    keys_raw = 8'h08;
    wait_stable(8'h08, 200, "t1_press_stable");
    chk("t1_lat0", s_valid, 0);
    step(); chk("t1_lat1", s_valid, 0);
    step(); chk("t1_lat2", s_valid, 1);
    chk("t1_press_data", s_data, 5'h03);
    keys_raw = 8'h00;
    wait_stable(8'h00, 200, "t1_rel_stable");
    step(); step();
    chk("t1_rel_valid", s_valid, 1);
    chk("t1_rel_data", s_data, 5'h0b);
    repeat (5) step();

    // bounce shorter than the debounce window
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      keys_raw[0] = ~keys_raw[0];
      repeat (2 * TD) begin step(); if (s_valid) seen = 1; end
    end
    keys_raw = 8'h00;
    repeat (6 * TD) begin step(); if (s_valid) seen = 1; end
    chk("t2_no_event", seen, 0);
    chk("t2_stable", s_stable, 0);

    // two keys in the same cycle
    keys_raw = 8'h81;
    wait_valid(300, "t3_wait");
    chk("t3_first", s_data, 5'h00);
    step();
    chk("t3_second_valid", s_valid, 1);
    chk("t3_second", s_data, 5'h07);
    keys_raw = 8'h00;
    wait_stable(8'h00, 200, "t3_rel_stable");
    repeat (12) step();

    // fill FIFO with consumer stalled, ninth event dropped
    ev_ready = 1'b0;
    keys_raw = 8'hff;
    wait_stable(8'hff, 200, "t4_press_stable");
    repeat (12) step();
    keys_raw = 8'hfe;
    wait_stable(8'hfe, 200, "t4_rel_stable");
    repeat (6) step();
    chk("t4_ovf_set", s_ovf, 1);
    chk("t4_valid", s_valid, 1);
    chk("t4_head", s_data, 5'h00);
    ev_ready = 1'b1; npop = 0;
    repeat (20) begin step(); if (popped) npop++; end
    chk("t4_drained", npop, 8);
    chk("t4_empty", s_valid, 0);
    chk("t4_ovf_sticky", s_ovf, 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    clr_overflow = 1'b1; step();
    clr_overflow = 1'b0; step();
    chk("t4_ovf_clr", s_ovf, 0);
    keys_raw = 8'h00;
    wait_stable(8'h00, 200, "t4_all_rel");
    repeat (20) step();

    // held key: auto-repeat only when enabled
    keys_raw = 8'h20;
    wait_stable(8'h20, 200, "t5_press_stable");
    nrep = 0;
    repeat (16 * TD) begin step(); if (popped && pop_data[4]) nrep++; end
    keys_raw = 8'h00;
    repeat (25 * TD) begin step(); if (popped && pop_data[4]) nrep++; end
    chk("t5_rel_stable", s_stable, 0);
`ifdef REPEAT_EN
    chk("t5_repeats", nrep, 4);
`else
    chk("t5_repeats", nrep, 0);
`endif

    // reset with queued events and a held key
    ev_ready = 1'b0;
    keys_raw = 8'h07;
    wait_stable(8'h07, 200, "t6_press_stable");
    repeat (5) step();
    chk("t6_queued", s_valid, 1);
    keys_raw = 8'h04; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t6_valid", s_valid, 0);
    chk("t6_stable", s_stable, 0);
    chk("t6_ovf", s_ovf, 0);
    ev_ready = 1'b1;
    wait_valid(DEB * TD + 40, "t6_wait");
    chk("t6_data", s_data, 5'h02);
    keys_raw = 8'h00;
    wait_stable(8'h00, 200, "t6_rel_stable");
    repeat (12) step();

    // random single-key activity with a jittery consumer
    for (int it = 0; it < 40; it++) begin
      b = $urandom_range(0, 7);
      hold = $urandom_range(1, DEB + 8) * TD + $urandom_range(0, TD - 1);
      keys_raw[b] = ~keys_raw[b];
      repeat (hold) begin
        ev_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    keys_raw = 8'h00; ev_ready = 1'b1;
    repeat ((DEB + 2) * TD + 20) step();
    chk("rnd_no_ovf", s_ovf, 0);
    chk("rnd_all_consumed", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
